// File: rtl/sram_array_ctrl_if.sv
// Bus bundle for sram_array_ctrl: client read/write handshakes, read response,
// init status, and the 1R/1W array port the controller drives.
interface sram_array_ctrl_if #(
   parameter int AW = 10,
   parameter int DW = 11
);
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          resp_valid;
   logic [DW-1:0] resp_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          init_done;
   logic [AW-1:0] R0_addr;
   logic          R0_en;
   logic [DW-1:0] R0_data;
   logic [AW-1:0] W0_addr;
   logic          W0_en;
   logic [DW-1:0] W0_data;

   modport slave (
      input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, R0_data,
      output rd_ready, resp_valid, resp_data, wr_ready, init_done,
             R0_addr, R0_en, W0_addr, W0_en, W0_data
   );

   modport master (
      output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, R0_data,
      input  rd_ready, resp_valid, resp_data, wr_ready, init_done,
             R0_addr, R0_en, W0_addr, W0_en, W0_data
   );
endinterface

// File: rtl/sram_array_ctrl.sv
// Controller for a 1R/1W synchronous SRAM: sweeps INIT_VAL into every entry after
// reset, then passes reads/writes through with 1-cycle read latency and write forwarding.
module sram_array_ctrl #(
   parameter int            DEPTH    = 1024,
   parameter int            AW       = 10,
   parameter int            DW       = 11,
   parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
   input logic               clock,
   input logic               reset_n,
   sram_array_ctrl_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   // Refuse to elaborate when the address width cannot exactly cover DEPTH.
   if ((64'd1 << AW) != 64'(DEPTH)) begin : g_bad_depth
      $error("sram_array_ctrl: 2**AW must equal DEPTH");
   end

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          resp_valid_q, resp_valid_d;
   logic          bypass_q, bypass_d;
   logic [DW-1:0] fwd_q, fwd_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          run_s;
   logic          rd_acc_s;
   logic          wr_acc_s;
   logic [DW-1:0] resp_data_s;

   assign run_s    = (state_q == ST_RUN);
   assign rd_acc_s = bus.rd_valid & run_s;
   assign wr_acc_s = bus.wr_valid & run_s;

   assign bus.rd_ready   = run_s;
   assign bus.wr_ready   = run_s;
   assign bus.init_done  = run_s;
   assign bus.R0_en      = rd_acc_s;
   assign bus.R0_addr    = bus.rd_addr;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_s;

   // State and register update; reset aborts any sweep or pending response.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         cnt_q        <= {AW{1'b0}};
         resp_valid_q <= 1'b0;
         bypass_q     <= 1'b0;
         fwd_q        <= INIT_VAL;
         hold_q       <= INIT_VAL;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         bypass_q     <= bypass_d;
         fwd_q        <= fwd_d;
         hold_q       <= hold_d;
      end
   end

   // Next-state: the sweep counter parks on the last address instead of wrapping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + ADDR_ONE;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = {AW{1'b0}};
         end
      endcase
   end

   // Array write port: sweep during INIT, client pass-through in RUN, quiet in reset.
   always_comb begin
      bus.W0_en   = 1'b0;
      bus.W0_addr = {AW{1'b0}};
      bus.W0_data = INIT_VAL;
      if (!reset_n) begin
         bus.W0_en = 1'b0;
      end else if (run_s) begin
         bus.W0_en   = bus.wr_valid;
         bus.W0_addr = bus.wr_addr;
         bus.W0_data = bus.wr_data;
      end else begin
         bus.W0_en   = 1'b1;
         bus.W0_addr = cnt_q;
         bus.W0_data = INIT_VAL;
      end
   end

   // Response path: same-address write data wins over the array's read-before-write data.
   always_comb begin
      resp_valid_d = rd_acc_s;
      bypass_d     = rd_acc_s & wr_acc_s & (bus.rd_addr == bus.wr_addr);
      if (bypass_d) begin
         fwd_d = bus.wr_data;
      end else begin
         fwd_d = fwd_q;
      end
      if (resp_valid_q) begin
         if (bypass_q) begin
            resp_data_s = fwd_q;
         end else begin
            resp_data_s = bus.R0_data;
         end
         hold_d = resp_data_s;
      end else begin
         resp_data_s = hold_q;
         hold_d      = hold_q;
      end
   end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Randomised bench for sram_array_ctrl: a behavioural SRAM plus a reference model
// of sweep, read latency, forwarding and hold behaviour, checked every cycle.
module tb_sram_array_ctrl;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int DW    = 11;
   localparam logic [DW-1:0] INIT_VAL = {DW{1'b0}};

   logic clock = 1'b0;
   logic reset_n = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   sram_array_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   sram_array_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VAL(INIT_VAL)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Behavioural synchronous 1R/1W array, read-before-write on collision.
   logic [DW-1:0] arr [DEPTH];
   always @(posedge clock) begin
      if (bus.W0_en) arr[bus.W0_addr] <= bus.W0_data;
      if (bus.R0_en) bus.R0_data <= arr[bus.R0_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_sweep = 0;
   logic          m_pend = 1'b0;
   logic [DW-1:0] m_pdata = INIT_VAL;
   logic [DW-1:0] m_hold = INIT_VAL;

   // Compare process: mid-cycle, check outputs against the model, then advance it past the edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
         chk("rst_init_done", 32'(bus.init_done), 32'd0);
         chk("rst_W0_en", 32'(bus.W0_en), 32'd0);
         chk("rst_R0_en", 32'(bus.R0_en), 32'd0);
         chk("rst_resp_data", 32'(bus.resp_data), 32'(INIT_VAL));
         m_sweep = 0;
         m_pend  = 1'b0;
         m_hold  = INIT_VAL;
      end else if (m_sweep < DEPTH) begin
         chk("init_W0_en", 32'(bus.W0_en), 32'd1);
         chk("init_W0_addr", 32'(bus.W0_addr), 32'(m_sweep));
         chk("init_W0_data", 32'(bus.W0_data), 32'(INIT_VAL));
         chk("init_rd_ready", 32'(bus.rd_ready), 32'd0);
         chk("init_wr_ready", 32'(bus.wr_ready), 32'd0);
         chk("init_init_done", 32'(bus.init_done), 32'd0);
         chk("init_R0_en", 32'(bus.R0_en), 32'd0);
         chk("init_resp_valid", 32'(bus.resp_valid), 32'd0);
         chk("init_resp_data", 32'(bus.resp_data), 32'(m_hold));
         m_sweep++;
         if (m_sweep == DEPTH) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = INIT_VAL;
         end
      end else begin
         chk("run_rd_ready", 32'(bus.rd_ready), 32'd1);
         chk("run_wr_ready", 32'(bus.wr_ready), 32'd1);
         chk("run_init_done", 32'(bus.init_done), 32'd1);
         chk("run_W0_en", 32'(bus.W0_en), 32'(bus.wr_valid));
         if (bus.wr_valid) begin
            chk("run_W0_addr", 32'(bus.W0_addr), 32'(bus.wr_addr));
            chk("run_W0_data", 32'(bus.W0_data), 32'(bus.wr_data));
         end
         chk("run_R0_en", 32'(bus.R0_en), 32'(bus.rd_valid));
         if (bus.rd_valid) chk("run_R0_addr", 32'(bus.R0_addr), 32'(bus.rd_addr));
         chk("run_resp_valid", 32'(bus.resp_valid), 32'(m_pend));
         chk("run_resp_data", 32'(bus.resp_data), m_pend ? 32'(m_pdata) : 32'(m_hold));
         if (m_pend) m_hold = m_pdata;
         m_pend = bus.rd_valid;
         if (bus.rd_valid) begin
            if (bus.wr_valid && bus.wr_addr == bus.rd_addr) m_pdata = bus.wr_data;
            else m_pdata = ref_mem[bus.rd_addr];
         end
         if (bus.wr_valid) ref_mem[bus.wr_addr] = bus.wr_data;
      end
   end

   // One cycle of stimulus with a hand-computed expectation for this cycle's response outputs.
   task automatic step(input string nm, input logic rv, input int ra, input logic wv,
                       input int wa, input int wd, input logic ev, input int ed);
      bus.rd_valid = rv;
      bus.rd_addr  = AW'(ra);
      bus.wr_valid = wv;
      bus.wr_addr  = AW'(wa);
      bus.wr_data  = DW'(wd);
      @(negedge clock);
      chk({nm, "_valid"}, 32'(bus.resp_valid), 32'(ev));
      chk({nm, "_data"}, 32'(bus.resp_data), 32'(ed));
      @(posedge clock);
      #1;
      bus.rd_valid = 1'b0;
      bus.wr_valid = 1'b0;
   endtask

   task automatic rand_cycle();
      bus.rd_valid = 1'($urandom_range(0, 1));
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.rd_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      bus.wr_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      bus.wr_data  = DW'($urandom);
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rd_valid = 1'b0;
      bus.wr_valid = 1'b0;
   endtask

   task automatic reset_pins(input string nm);
      chk({nm, "_W0_en"}, 32'(bus.W0_en), 32'd0);
      chk({nm, "_R0_en"}, 32'(bus.R0_en), 32'd0);
      chk({nm, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      chk({nm, "_init_done"}, 32'(bus.init_done), 32'd0);
      chk({nm, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) arr[i] = DW'($urandom);
      bus.R0_data  = DW'($urandom);
      bus.rd_valid = 1'b0;
      bus.rd_addr  = {AW{1'b0}};
      bus.wr_valid = 1'b0;
      bus.wr_addr  = {AW{1'b0}};
      bus.wr_data  = {DW{1'b0}};
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Sweep length: still initialising on cycle 1024, done on cycle 1025.
      repeat (DEPTH) @(negedge clock);
      chk("sweep_last_init_done", 32'(bus.init_done), 32'd0);
      chk("sweep_last_addr", 32'(bus.W0_addr), 32'd1023);
      chk("sweep_last_en", 32'(bus.W0_en), 32'd1);
      @(negedge clock);
      chk("sweep_done", 32'(bus.init_done), 32'd1);
      chk("sweep_done_W0_en", 32'(bus.W0_en), 32'd0);
      @(posedge clock);
      #1;

      // Read of a freshly initialised entry, then hold.
      step("rd5_req", 1'b1, 5, 1'b0, 0, 0, 1'b0, 0);
      step("rd5_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 0);
      for (int i = 0; i < 10; i++) step("rd5_hold", 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);

      // Write then read next cycle.
      step("wr3", 1'b0, 0, 1'b1, 3, 'h7FF, 1'b0, 0);
      step("rd3_req", 1'b1, 3, 1'b0, 0, 0, 1'b0, 0);
      step("rd3_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h7FF);
      step("rd3_hold", 1'b0, 0, 1'b0, 0, 0, 1'b0, 'h7FF);

      // A write during the response cycle does not disturb that response.
      step("rd3b_req", 1'b1, 3, 1'b0, 0, 0, 1'b0, 'h7FF);
      step("rd3b_resp_wr", 1'b0, 0, 1'b1, 3, 'h0AA, 1'b1, 'h7FF);
      step("rd3b_hold", 1'b0, 0, 1'b0, 0, 0, 1'b0, 'h7FF);
      step("rd3c_req", 1'b1, 3, 1'b0, 0, 0, 1'b0, 'h7FF);
      step("rd3c_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h0AA);

      // Same-address forwarding, then different-address concurrency.
      step("fwd9_req", 1'b1, 9, 1'b1, 9, 'h155, 1'b0, 'h0AA);
      step("fwd9_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h155);
      step("rd5b_req", 1'b1, 5, 1'b0, 0, 0, 1'b0, 'h155);
      step("rd9_wr8", 1'b1, 9, 1'b1, 8, 'h066, 1'b1, 0);
      step("rd9_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h155);
      step("rd8_req", 1'b1, 8, 1'b0, 0, 0, 1'b0, 'h155);
      step("rd8_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h066);

      // Back-to-back reads give back-to-back responses.
      step("wr1", 1'b0, 0, 1'b1, 1, 'h001, 1'b0, 'h066);
      step("wr2", 1'b0, 0, 1'b1, 2, 'h002, 1'b0, 'h066);
      step("wr3b", 1'b0, 0, 1'b1, 3, 'h003, 1'b0, 'h066);
      step("b2b_rd1", 1'b1, 1, 1'b0, 0, 0, 1'b0, 'h066);
      step("b2b_rd2", 1'b1, 2, 1'b0, 0, 0, 1'b1, 'h001);
      step("b2b_rd3", 1'b1, 3, 1'b0, 0, 0, 1'b1, 'h002);
      step("b2b_last", 1'b0, 0, 1'b0, 0, 0, 1'b1, 'h003);
      step("b2b_hold", 1'b0, 0, 1'b0, 0, 0, 1'b0, 'h003);

      for (int i = 0; i < 3000; i++) rand_cycle();

      // Reset while a read response is due.
      bus.rd_valid = 1'b1;
      bus.rd_addr  = AW'(3);
      bus.wr_valid = 1'b0;
      @(posedge clock);
      #1;
      idle_inputs();
      reset_n = 1'b0;
      #1;
      reset_pins("rst_midread");
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Partial sweep with requests pending, then reset at address 500.
      for (int i = 0; i < 500; i++) rand_cycle();
      chk("sweep500_addr", 32'(bus.W0_addr), 32'd500);
      idle_inputs();
      reset_n = 1'b0;
      #1;
      reset_pins("rst_sweep500");
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) rand_cycle();
      idle_inputs();
      @(negedge clock);
      chk("resweep_done", 32'(bus.init_done), 32'd1);
      chk("resweep_rd_ready", 32'(bus.rd_ready), 32'd1);
      @(posedge clock);
      #1;
      step("post_rd9", 1'b1, 9, 1'b0, 0, 0, 1'b0, 0);
      step("post_rd9_resp", 1'b0, 0, 1'b0, 0, 0, 1'b1, 0);
      for (int i = 0; i < 200; i++) rand_cycle();
      idle_inputs();
      repeat (2) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_array_ctrl.md
SRAM_ARRAY_CTRL -- requirements
Module: sram_array_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024: number of array entries.
REQ-002 Parameter AW, default 10: address width; the block SHALL require 2^AW == DEPTH.
REQ-003 Parameter DW, default 11: data width.
REQ-004 Parameter INIT_VAL, default 0 (DW bits): value written to every entry during the init sweep.
REQ-005 clock  in  1  single clock; the block, and the array it drives, SHALL be clocked on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rd_valid  in  1  read request valid.
REQ-008 rd_ready  out  1  read request accepted when rd_valid && rd_ready.
REQ-009 rd_addr  in  AW  read address.
REQ-010 resp_valid  out  1  one-cycle pulse marking a read response.
REQ-011 resp_data  out  DW  read data; held stable between responses.
REQ-012 wr_valid  in  1  write request valid.
REQ-013 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-014 wr_addr  in  AW  write address.
REQ-015 wr_data  in  DW  write data.
REQ-016 init_done  out  1  high once the init sweep has completed.
REQ-017 R0_addr  out  AW  array read address.
REQ-018 R0_en  out  1  array read enable.
REQ-019 R0_data  in  DW  array read data; valid in the cycle after an R0_en cycle.
REQ-020 W0_addr  out  AW  array write address.
REQ-021 W0_en  out  1  array write enable.
REQ-022 W0_data  out  DW  array write data.

Function
REQ-023 FSM states SHALL be INIT and RUN; reset SHALL enter INIT with the sweep counter set to 0.
REQ-024 INIT: each cycle SHALL drive W0_en=1, W0_addr=counter, W0_data=INIT_VAL, then increment the counter.
REQ-025 INIT SHALL move to RUN on the cycle after address DEPTH-1 is written, so the sweep takes exactly DEPTH cycles.
REQ-026 INIT: rd_ready, wr_ready, init_done and R0_en SHALL all be 0.
REQ-027 RUN: rd_ready, wr_ready and init_done SHALL all be 1.
REQ-028 RUN write: W0_en = wr_valid, W0_addr = wr_addr, W0_data = wr_data, all combinational (zero latency).
REQ-029 RUN read: R0_en = rd_valid and R0_addr = rd_addr, both combinational.
REQ-030 resp_valid SHALL be 1 exactly in the cycle after an accepted read, giving a fixed read latency of 1; back-to-back reads SHALL give back-to-back responses.
REQ-031 In a response cycle, resp_data SHALL equal R0_data combinationally, and that value SHALL be captured into a hold register.
REQ-032 In every other cycle, resp_data SHALL equal the hold register.
REQ-033 Same-cycle read and write to the same address SHALL be forwarded: the response carries that cycle's wr_data, not R0_data.
  - Forwarding SHALL use a registered bypass flag plus the registered data.
REQ-034 A write issued during the response cycle SHALL NOT alter that response.
REQ-035 A read and a write to different addresses in the same cycle SHALL both proceed; there is no port arbitration.
REQ-036 Address wrap: the sweep counter SHALL stop at DEPTH-1; it SHALL NOT wrap or rewrite entries.

Reset
REQ-037 While reset_n=0, the block SHALL asynchronously drive:
  - state=INIT, counter=0, hold register=INIT_VAL, bypass flag=0;
  - resp_valid=0, init_done=0, W0_en=0, R0_en=0.
REQ-038 The first sweep write SHALL occur in the first cycle after reset_n deasserts.
REQ-039 Reset asserted mid-sweep or mid-read SHALL abort the operation.
  - No resp_valid SHALL be emitted for a read accepted before the reset.
  - The full sweep SHALL restart from address 0.

Verification
REQ-040 Reset release -> W0_en high for exactly 1024 cycles, addresses 0..1023, data 0; init_done rises in cycle 1025.
REQ-041 After init, read addr 5 -> resp_valid the next cycle, resp_data=0x000; resp_data stays 0x000 for 10 idle cycles.
REQ-042 Write 0x7FF to addr 3; next cycle read addr 3 -> response 0x7FF, 1 cycle after the read.
REQ-043 Same cycle: write 0x155 to addr 9 and read addr 9 -> response 0x155.
  - Same cycle, different addresses: write addr 8, read addr 9 -> response equals the old addr 9 contents.
REQ-044 Reads to addrs 1,2,3 on three consecutive cycles (contents 0x001/0x002/0x003) -> three consecutive resp_valid pulses, data 0x001, 0x002, 0x003.
REQ-045 Assert reset_n=0 at sweep address 500 -> outputs clear immediately; after release the sweep restarts at 0, takes 1024 cycles, and rd_ready stays 0 throughout.
